exhaustive_vector_checker: RTL
==============================

Name: exhaustive_vector_checker

Overview:
Synthesizable, parametrised self-checking harness for small combinational blocks.
- Sweeps every input combination of an N_IN-bit DUT.
- Waits a configurable number of settle cycles per vector, then compares the DUT output against a golden-model output.
- Counts mismatches, captures the first failing vector and reports pass/fail.
- Sits between a DUT and its golden model (both combinational, both fed from `stim`) inside the lab test harnesses.
- Generalises the free-running sweep-and-compare bench: adds clocked sequencing, start/done handshake, a loop mode, error counting and first-failure capture.

Parameters:
- N_IN, 3, width of the DUT input vector; sweep covers 0 .. 2^N_IN-1.
- N_OUT, 1, width of the DUT and golden outputs.
- SETTLE, 2, cycles each vector is held before its compare; legal range 1..255.
- ERR_W, 8, width of the error counter; the counter saturates.

Ports:
- clk  in  1  single system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a sweep; sampled only in IDLE or DONE.
- loop  in  1  1 = wrap and sweep forever; sampled at every wrap point.
- stim  out  N_IN  vector applied to both DUT and golden model.
- dut_out  in  N_OUT  DUT response.
- golden  in  N_OUT  expected response.
- busy  out  1  high in SETTLE and CHECK.
- done  out  1  high in DONE.
- pass  out  1  valid when done=1; equals (err_count==0).
- chk_valid  out  1  one-cycle pulse per completed compare.
- chk_ok  out  1  result of the latest compare; updated with chk_valid.
- err_count  out  ERR_W  number of mismatches; saturates at all-ones.
- first_err_valid  out  1  set on the first mismatch since start.
- first_err_vec  out  N_IN  stim value at the first mismatch.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE. All outputs are 0: stim, busy, done, pass, chk_valid, chk_ok, err_count, first_err_valid, first_err_vec. The settle counter is 0. Reset wins over all other inputs, including mid-sweep.
- States are IDLE, SETTLE, CHECK and DONE.
- IDLE, start=1:
  - next state SETTLE, stim<=0, settle_cnt<=0.
  - err_count, first_err_valid, first_err_vec and chk_ok are cleared.
- SETTLE:
  - settle_cnt increments each cycle.
  - When settle_cnt==SETTLE-1, go to CHECK.
  - stim is therefore stable for exactly SETTLE cycles before CHECK.
- CHECK (one cycle): compare dut_out against golden over all N_OUT bits. On the exit edge:
  - chk_valid<=1 for one cycle; chk_ok<=(dut_out==golden).
  - On a mismatch: err_count<=err_count+1 unless already all-ones. If first_err_valid==0, set it and latch first_err_vec<=stim.
  - If stim != all-ones: stim<=stim+1, settle_cnt<=0, go to SETTLE.
  - If stim == all-ones and loop=1: stim<=0 (wrap), go to SETTLE. Counters are not cleared, so errors accumulate across passes.
  - If stim == all-ones and loop=0: go to DONE; stim holds all-ones.
- DONE:
  - done=1 and pass=(err_count==0); all results held.
  - start=1 restarts the sweep exactly as from IDLE.
- start is ignored while busy=1.
- Clearing loop mid-pass ends the run at the next wrap point.
- Latency: each vector takes SETTLE+1 cycles. Done rises (SETTLE+1)*2^N_IN cycles after the edge that samples start. With the defaults this is 24 cycles.
- Widths: stim increments modulo 2^N_IN; no extra carry bit is used.

Test Plan:
1. Defaults; golden = a&b&~c on stim={a,b,c}; dut_out driven from the same function; pulse start → after 24 cycles: done=1, pass=1, err_count=0, first_err_valid=0, 8 chk_valid pulses with chk_ok=1.
2. dut_out=a&b (faulty), golden as in 1 → err_count=1, first_err_vec=3'b111, pass=0; chk_ok=0 only on the last pulse.
3. dut_out stuck at 1, ERR_W=2 → 7 mismatches, err_count saturates at 3, first_err_vec=3'b000.
4. loop=1, dut_out stuck at 0 → stim wraps 7→0, done stays 0; err_count=1 after pass 1 and 2 after pass 2. Drop loop → DONE at the end of the current pass.
5. rst=1 asserted while stim=4 → next cycle: state=IDLE, stim=0, busy=0, err_count=0. A later start restarts a full 24-cycle sweep.
6. start pulsed while busy → no effect on stim or timing. SETTLE=1 → done after 16 cycles.

Source files
------------

// File: rtl/exhaustive_vector_checker.sv
// Clocked sweep-and-compare harness: walks every N_IN-bit vector, holds it SETTLE cycles,
// then compares DUT against golden, counting mismatches and capturing the first failure.
`timescale 1ns/1ps
module exhaustive_vector_checker #(
   parameter int N_IN   = 3,
   parameter int N_OUT  = 1,
   parameter int SETTLE = 2,
   parameter int ERR_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              loop,
   output logic [N_IN-1:0]   stim,
   input  logic [N_OUT-1:0]  dut_out,
   input  logic [N_OUT-1:0]  golden,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic              chk_valid,
   output logic              chk_ok,
   output logic [ERR_W-1:0]  err_count,
   output logic              first_err_valid,
   output logic [N_IN-1:0]   first_err_vec
);
   localparam int CNT_W = 8;
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);
   localparam logic [N_IN-1:0]  STIM_MAX    = '1;
   localparam logic [ERR_W-1:0] ERR_MAX     = '1;

   typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_CHECK, ST_DONE} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] settle_cnt_q, settle_cnt_d;
   logic [N_IN-1:0]  stim_q, stim_d;
   logic             chk_valid_q, chk_valid_d;
   logic             chk_ok_q, chk_ok_d;
   logic [ERR_W-1:0] err_count_q, err_count_d;
   logic             first_err_valid_q, first_err_valid_d;
   logic [N_IN-1:0]  first_err_vec_q, first_err_vec_d;
   logic             match;

   assign match = (dut_out == golden);

   always_comb begin
      state_d           = state_q;
      settle_cnt_d      = settle_cnt_q;
      stim_d            = stim_q;
      chk_valid_d       = 1'b0;
      chk_ok_d          = chk_ok_q;
      err_count_d       = err_count_q;
      first_err_valid_d = first_err_valid_q;
      first_err_vec_d   = first_err_vec_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d           = ST_SETTLE;
               stim_d            = '0;
               settle_cnt_d      = '0;
               err_count_d       = '0;
               first_err_valid_d = 1'b0;
               first_err_vec_d   = '0;
               chk_ok_d          = 1'b0;
            end
         end
         ST_SETTLE: begin
            settle_cnt_d = settle_cnt_q + 1'b1;
            if (settle_cnt_q == SETTLE_LAST) begin
               state_d = ST_CHECK;
            end
         end
         ST_CHECK: begin
            chk_valid_d  = 1'b1;
            chk_ok_d     = match;
            settle_cnt_d = '0;
            if (!match) begin
               if (err_count_q != ERR_MAX) begin
                  err_count_d = err_count_q + 1'b1;
               end
               if (!first_err_valid_q) begin
                  first_err_valid_d = 1'b1;
                  first_err_vec_d   = stim_q;
               end
            end
            // At the top vector, loop decides between wrapping and finishing.
            if (stim_q != STIM_MAX) begin
               stim_d  = stim_q + 1'b1;
               state_d = ST_SETTLE;
            end else if (loop) begin
               stim_d  = '0;
               state_d = ST_SETTLE;
            end else begin
               state_d = ST_DONE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q           <= ST_IDLE;
         settle_cnt_q      <= '0;
         stim_q            <= '0;
         chk_valid_q       <= 1'b0;
         chk_ok_q          <= 1'b0;
         err_count_q       <= '0;
         first_err_valid_q <= 1'b0;
         first_err_vec_q   <= '0;
      end else begin
         state_q           <= state_d;
         settle_cnt_q      <= settle_cnt_d;
         stim_q            <= stim_d;
         chk_valid_q       <= chk_valid_d;
         chk_ok_q          <= chk_ok_d;
         err_count_q       <= err_count_d;
         first_err_valid_q <= first_err_valid_d;
         first_err_vec_q   <= first_err_vec_d;
      end
   end

   assign stim            = stim_q;
   assign busy            = (state_q == ST_SETTLE) || (state_q == ST_CHECK);
   assign done            = (state_q == ST_DONE);
   assign pass            = (state_q == ST_DONE) && (err_count_q == '0);
   assign chk_valid       = chk_valid_q;
   assign chk_ok          = chk_ok_q;
   assign err_count       = err_count_q;
   assign first_err_valid = first_err_valid_q;
   assign first_err_vec   = first_err_vec_q;
endmodule
